// File: rtl/uart_txs.sv
// Multi-byte 8N1 UART transmitter: sends MulTXNum bytes of idats, byte 0 first, LSB first.
// One cycle from accepted start to the start bit; bytes are sent with no idle gap between them.
module uart_txs #(
   parameter int MulTXNum = 3,
   parameter int CLKFreq  = 50000000,
   parameter int UARTBaud = 115200
) (
   input  logic                    sys_clk,
   input  logic                    rst_n,
   input  logic                    uart_txs_start,
   input  logic [MulTXNum*8-1:0]   idats,
   output logic                    uart_txs_busy,
   output logic                    uart_txs_done,
   output logic                    uarttx
);

   localparam int BP = CLKFreq / UARTBaud;
   localparam int CW = (BP > 1) ? $clog2(BP) : 1;
   localparam int NW = (MulTXNum > 1) ? $clog2(MulTXNum) : 1;
   localparam logic [CW-1:0] BP_LAST   = CW'(BP - 1);
   localparam logic [NW-1:0] BYTE_LAST = NW'(MulTXNum - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [CW-1:0]           tick_cnt;
   logic [2:0]              bit_idx;
   logic [NW-1:0]           byte_idx;
   logic [MulTXNum*8-1:0]   shreg;
   logic                    bit_end;
   logic                    last_byte;

   assign bit_end   = (tick_cnt == BP_LAST);
   assign last_byte = (byte_idx == BYTE_LAST);

   always_comb begin
      state_nxt     = state;
      uart_txs_busy = 1'b0;
      uart_txs_done = 1'b0;
      case (state)
         IDLE: begin
            if (uart_txs_start) state_nxt = START;
         end
         START: begin
            uart_txs_busy = 1'b1;
            if (bit_end) state_nxt = DATA;
         end
         DATA: begin
            uart_txs_busy = 1'b1;
            if (bit_end && bit_idx == 3'd7) state_nxt = STOP;
         end
         STOP: begin
            uart_txs_busy = 1'b1;
            if (bit_end) begin
               if (last_byte) begin
                  state_nxt     = IDLE;
                  uart_txs_done = 1'b1;
               end else begin
                  state_nxt = START;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         tick_cnt <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         shreg    <= '0;
         uarttx   <= 1'b1;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               tick_cnt <= '0;
               bit_idx  <= '0;
               byte_idx <= '0;
               if (uart_txs_start) begin
                  shreg  <= idats;
                  uarttx <= 1'b0;
               end
            end
            START: begin
               if (bit_end) begin
                  tick_cnt <= '0;
                  uarttx   <= shreg[0];
               end else begin
                  tick_cnt <= tick_cnt + CW'(1);
               end
            end
            DATA: begin
               // Shifting one bit per data bit leaves the next byte in the low lane after eight.
               if (bit_end) begin
                  tick_cnt <= '0;
                  shreg    <= shreg >> 1;
                  if (bit_idx == 3'd7) begin
                     bit_idx <= '0;
                     uarttx  <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     uarttx  <= shreg[1];
                  end
               end else begin
                  tick_cnt <= tick_cnt + CW'(1);
               end
            end
            STOP: begin
               if (bit_end) begin
                  tick_cnt <= '0;
                  if (last_byte) begin
                     byte_idx <= '0;
                     uarttx   <= 1'b1;
                  end else begin
                     byte_idx <= byte_idx + NW'(1);
                     uarttx   <= 1'b0;
                  end
               end else begin
                  tick_cnt <= tick_cnt + CW'(1);
               end
            end
            default: begin
               tick_cnt <= '0;
               uarttx   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_txs.sv
// Directed bench for uart_txs: a 3-byte instance driven from a vector table plus a 1-byte instance.
// Line bits are checked every cycle and decoded mid-bit into a received word.
module tb_uart_txs;

   localparam int BP = 50000000 / 115200;

   logic        sys_clk;
   logic        rst_n;
   logic        start3, start1;
   logic [23:0] idats3;
   logic [7:0]  idats1;
   logic        busy3, done3, tx3;
   logic        busy1, done1, tx1;

   int total = 0;
   int bad   = 0;

   uart_txs #(.MulTXNum(3)) u3 (
      .sys_clk(sys_clk), .rst_n(rst_n), .uart_txs_start(start3), .idats(idats3),
      .uart_txs_busy(busy3), .uart_txs_done(done3), .uarttx(tx3)
   );

   uart_txs #(.MulTXNum(1)) u1 (
      .sys_clk(sys_clk), .rst_n(rst_n), .uart_txs_start(start1), .idats(idats1),
      .uart_txs_busy(busy1), .uart_txs_done(done1), .uarttx(tx1)
   );

   initial sys_clk = 1'b0;
   always #10 sys_clk = ~sys_clk;

   typedef struct {
      logic [23:0] dat;
      logic [23:0] exp_word;
      logic [9:0]  exp_f0;
      int          ignore_at;
      bit          start_in_done;
      bit          pre_reset;
   } vec_t;

   vec_t vecs[3];

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic line_of(input int sel);
      return (sel == 0) ? tx3 : tx1;
   endfunction
   function automatic logic busy_of(input int sel);
      return (sel == 0) ? busy3 : busy1;
   endfunction
   function automatic logic done_of(input int sel);
      return (sel == 0) ? done3 : done1;
   endfunction

   // Starts a transfer from an idle cycle and returns positioned in the expected done cycle.
   task automatic run_xfer(input int sel, input int nb, input logic [23:0] dat,
                           input logic [23:0] exp_word, input logic [9:0] exp_f0,
                           input int ignore_at, input string nm);
      int idx, done_cnt, done_idx, bad_bits, busy_bad, errb;
      logic e;
      logic [7:0]  rb;
      logic [9:0]  f0;
      logic [23:0] word;
      idx = 0; done_cnt = 0; done_idx = -1; bad_bits = 0; busy_bad = 0;
      rb = '0; f0 = '0; word = '0;
      if (sel == 0) begin idats3 = dat; start3 = 1'b1; end
      else begin idats1 = dat[7:0]; start1 = 1'b1; end
      tick();
      start3 = 1'b0; start1 = 1'b0;
      chk({nm, "_start_latency"}, {31'd0, line_of(sel)}, 32'd0);
      for (int b = 0; b < nb; b++) begin
         for (int k = 0; k < 10; k++) begin
            e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : dat[8*b + k - 1];
            errb = 0;
            for (int c = 0; c < BP; c++) begin
               idx++;
               if (line_of(sel) !== e) errb++;
               if (busy_of(sel) !== 1'b1) busy_bad++;
               if (done_of(sel) === 1'b1) begin done_cnt++; done_idx = idx; end
               if (c == BP/2) begin
                  if (k >= 1 && k <= 8) rb[k-1] = line_of(sel);
                  if (b == 0) f0[k] = line_of(sel);
               end
               if (idx == ignore_at) begin start3 = 1'b1; idats3 = ~dat; end
               if (!(b == nb-1 && k == 9 && c == BP-1)) begin
                  tick();
                  start3 = 1'b0;
               end
            end
            if (errb != 0) bad_bits++;
            if (k == 9) word = {rb, word[23:8]};
         end
      end
      chk({nm, "_line_bits"}, bad_bits, 0);
      chk({nm, "_busy_high"}, busy_bad, 0);
      chk({nm, "_done_count"}, done_cnt, 1);
      chk({nm, "_done_time"}, done_idx, nb*10*BP);
      chk({nm, "_frame0"}, {22'd0, f0}, {22'd0, exp_f0});
      chk({nm, "_rx_word"}, word >> (8*(3-nb)), exp_word);
   endtask

   // Aborts a transfer during byte 1 data bits; start is also held high in the reset cycle.
   task automatic mid_reset();
      int dn, err;
      dn = 0; err = 0;
      idats3 = 24'h5A5A5A; start3 = 1'b1;
      tick();
      start3 = 1'b0;
      for (int n = 1; n < 13*BP; n++) begin
         if (done3 === 1'b1) dn++;
         tick();
      end
      chk("rst_pre_busy", {31'd0, busy3}, 32'd1);
      rst_n = 1'b0; start3 = 1'b1;
      tick();
      rst_n = 1'b1; start3 = 1'b0;
      chk("rst_mid_line", {31'd0, tx3}, 32'd1);
      chk("rst_mid_busy", {31'd0, busy3}, 32'd0);
      chk("rst_mid_done", {31'd0, done3}, 32'd0);
      for (int n = 0; n < 3*BP; n++) begin
         tick();
         if (tx3 !== 1'b1 || busy3 !== 1'b0 || done3 !== 1'b0) err++;
      end
      chk("rst_no_done_before", dn, 0);
      chk("rst_no_resume", err, 0);
   endtask

   initial begin
      vecs[0] = '{dat: 24'h332211, exp_word: 24'h332211, exp_f0: 10'b1000100010,
                  ignore_at: -1, start_in_done: 1'b1, pre_reset: 1'b0};
      vecs[1] = '{dat: 24'hFF00A5, exp_word: 24'hFF00A5, exp_f0: 10'b1101001010,
                  ignore_at: 5000, start_in_done: 1'b0, pre_reset: 1'b0};
      vecs[2] = '{dat: 24'h800001, exp_word: 24'h800001, exp_f0: 10'b1000000010,
                  ignore_at: -1, start_in_done: 1'b0, pre_reset: 1'b1};

      rst_n = 1'b0; start3 = 1'b0; start1 = 1'b0; idats3 = '0; idats1 = '0;
      repeat (3) tick();
      chk("reset_line", {31'd0, tx3}, 32'd1);
      chk("reset_busy", {31'd0, busy3}, 32'd0);
      chk("reset_done", {31'd0, done3}, 32'd0);
      chk("reset_line1", {31'd0, tx1}, 32'd1);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 3; i++) begin
         if (vecs[i].pre_reset) mid_reset();
         run_xfer(0, 3, vecs[i].dat, vecs[i].exp_word, vecs[i].exp_f0,
                  vecs[i].ignore_at, $sformatf("v%0d", i));
         if (vecs[i].start_in_done) begin
            start3 = 1'b1; idats3 = 24'hC0FFEE;
         end
         tick();
         start3 = 1'b0;
         if (vecs[i].start_in_done) begin
            chk("done_start_busy", {31'd0, busy3}, 32'd0);
            chk("done_start_line", {31'd0, tx3}, 32'd1);
         end
      end

      run_xfer(1, 1, 24'h0000A5, 24'h0000A5, 10'b1101001010, -1, "m1");
      tick();
      chk("m1_idle_busy", {31'd0, busy1}, 32'd0);
      chk("m1_idle_line", {31'd0, tx1}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
